// File: rtl/verificador_contador.sv
// -----------------------------------------------------------------------------
// verificador_contador
//   Receive-side integrity monitor for a mod-MODULO up-counter bus. It locks
//   onto the 0 -> 1 -> ... -> MODULO-1 -> 0 sequence after LOCK_COUNT
//   consecutive correct successors. It then flags deviations, counts them in a
//   saturating counter and pulses on every correct wrap.
//
// Ports
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-high reset, highest priority
//   en        in   sample strobe; S is evaluated only when en=1
//   S         in   [WIDTH-1:0] counter value under check
//   locked    out  high while the sequence is being tracked
//   erro      out  one-cycle pulse on a mismatch while locked
//   wrap      out  one-cycle pulse on a correct MODULO-1 -> 0 step while locked
//   invalido  out  one-cycle pulse when a sampled S >= MODULO
//   expected  out  [WIDTH-1:0] next(prev) while locked, 0 otherwise
//   err_count out  [ERR_W-1:0] saturating count of erro pulses
//
// All outputs are registered, so a sample taken at edge N shows up after
// edge N.
// -----------------------------------------------------------------------------
module verificador_contador #(
  parameter int MODULO     = 5,
  parameter int WIDTH      = 3,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] S,
  output logic             locked,
  output logic             erro,
  output logic             wrap,
  output logic             invalido,
  output logic [WIDTH-1:0] expected,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [GW-1:0]    LC      = GW'(LOCK_COUNT);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Successor in the counter sequence.
  function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] x);
    return (x == MAXV) ? '0 : x + WIDTH'(1);
  endfunction

  // Error counter holds at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [GW-1:0]    good_q, good_d;
  logic             locked_q, locked_d;
  logic             erro_q, erro_d;
  logic             wrap_q, wrap_d;
  logic             inval_q, inval_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic          s_valid;
  logic          s_match;
  logic [GW-1:0] good_inc;

  // The S < MODULO test is done one bit wider so MODULO == 2^WIDTH is legal.
  assign s_valid  = ({1'b0, S} < MOD_EXT);
  assign s_match  = (S == succ(prev_q));
  // good never reaches LOCK_COUNT while in SYNC, so this cannot overflow.
  assign good_inc = good_q + GW'(1);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    good_d     = good_q;
    locked_d   = locked_q;
    expected_d = expected_q;
    err_cnt_d  = err_cnt_q;
    erro_d     = 1'b0;
    wrap_d     = 1'b0;
    inval_d    = 1'b0;

    if (en) begin
      if (!s_valid) begin
        // Out-of-range values always force a full re-acquisition.
        inval_d    = 1'b1;
        state_d    = ST_HUNT;
        good_d     = '0;
        locked_d   = 1'b0;
        expected_d = '0;
        if (state_q == ST_LOCKED) begin
          erro_d    = 1'b1;
          err_cnt_d = sat_inc(err_cnt_q);
        end
      end else begin
        case (state_q)
          ST_HUNT: begin
            prev_d  = S;
            good_d  = '0;
            state_d = ST_SYNC;
          end
          ST_SYNC: begin
            prev_d = S;
            if (s_match) begin
              good_d = good_inc;
              if (good_inc == LC) begin
                state_d    = ST_LOCKED;
                locked_d   = 1'b1;
                expected_d = succ(S);
              end
            end else begin
              good_d = '0;
            end
          end
          ST_LOCKED: begin
            prev_d = S;
            if (s_match) begin
              expected_d = succ(S);
              wrap_d     = (prev_q == MAXV) && (S == '0);
            end else begin
              // The mismatching value becomes the new sync anchor.
              erro_d     = 1'b1;
              err_cnt_d  = sat_inc(err_cnt_q);
              locked_d   = 1'b0;
              good_d     = '0;
              state_d    = ST_SYNC;
              expected_d = '0;
            end
          end
          default: begin
            state_d    = ST_HUNT;
            good_d     = '0;
            locked_d   = 1'b0;
            expected_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      prev_q     <= '0;
      good_q     <= '0;
      locked_q   <= 1'b0;
      erro_q     <= 1'b0;
      wrap_q     <= 1'b0;
      inval_q    <= 1'b0;
      expected_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
      erro_q     <= erro_d;
      wrap_q     <= wrap_d;
      inval_q    <= inval_d;
      expected_q <= expected_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign erro      = erro_q;
  assign wrap      = wrap_q;
  assign invalido  = inval_q;
  assign expected  = expected_q;
  assign err_count = err_cnt_q;

endmodule

// File: doc/verificador_contador.md
Name: verificador_contador

Overview:
Sequence checker for the 3-bit up-counter bus produced by the mod-5 counter. It receives the counter value `S` on each sample strobe and locks onto the 0→1→2→3→4→0 sequence. Once locked, it flags any deviation, counts errors, and pulses on each wrap. It sits on the receive side of the counter bus and serves as the in-system integrity monitor for the counter output.

Parameters:
MODULO, 5, count modulus; legal values 0..MODULO-1; constraint 2 ≤ MODULO ≤ 2^WIDTH
WIDTH, 3, width of S
LOCK_COUNT, 3, consecutive correct successors required to assert locked (≥1)
ERR_W, 8, width of the saturating error counter

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
en  input  1  sample strobe; S is evaluated only on edges where en=1
S  input  WIDTH  counter value under check
locked  output  1  high while the sequence is tracked
erro  output  1  one-cycle pulse on sequence mismatch while locked
wrap  output  1  one-cycle pulse on a correct MODULO-1→0 transition while locked
invalido  output  1  one-cycle pulse when a sampled S ≥ MODULO
expected  output  WIDTH  next(prev); meaningful only while locked, 0 otherwise
err_count  output  ERR_W  number of erro pulses, saturating

Behaviour:
- Outputs and reset:
  - All outputs are registered.
  - Effects of a sample at edge N are visible after edge N (latency 1 cycle).
  - Reset (sync, active-high) has priority over everything. On the next edge it sets: state=HUNT, prev=0, good=0, locked=0, erro=0, wrap=0, invalido=0, expected=0, err_count=0.
  - Reset asserted mid-lock drops `locked` and clears `err_count` on that edge.
- Successor function: next(x) = (x == MODULO-1) ? 0 : x+1, computed in WIDTH bits.
- Idle behaviour: en=0 means no state change, and erro/wrap/invalido are 0 that cycle. Pulses never last more than one cycle.
- Valid sample: S < MODULO. Any S ≥ MODULO sampled in any state:
  - invalido=1, state→HUNT, good=0, locked=0.
  - If the state was LOCKED, erro=1 and err_count is also incremented.
- HUNT (valid S): prev←S, good←0, state→SYNC.
- SYNC:
  - S == next(prev): prev←S, good←good+1. If good+1 == LOCK_COUNT, then state→LOCKED, locked←1, expected←next(S).
  - Valid mismatch: prev←S, good←0, stay in SYNC. No erro, no err_count change.
- LOCKED:
  - S == next(prev): prev←S, expected←next(S). wrap=1 if prev == MODULO-1 and S == 0.
  - Valid mismatch (including a repeated value S == prev):
    - erro=1 and err_count←err_count+1, saturating at 2^ERR_W-1.
    - locked←0, prev←S, good←0, state→SYNC.
    - The mismatching sample becomes the new sync anchor.
- err_count holds at all-ones once saturated; it is cleared only by reset.
- good uses clog2(LOCK_COUNT+1) bits and never exceeds LOCK_COUNT.
- locked is 1 exactly when state == LOCKED.

Test Plan:
- Lock-in: reset, then en=1 each cycle with S = 0,1,2,3,4,0 → locked=0 after samples 1–3, locked=1 after sample 4 (S=3) with expected=4; wrap=1 only after the S=0 sample; err_count=0.
- Mismatch while locked: once locked, feed S = 4,0,2 → erro=1 for exactly one cycle after S=2, err_count=1, locked=0. Then feed 3,4,0 → locked=1 again after S=0, expected=1.
- Invalid value: while locked, feed S=6 → invalido=1 and erro=1 in the same cycle, err_count incremented, state HUNT. Then feed 1,2,3,4 → locked=1 after S=4.
- Strobe gating: locked, hold en=0 for 5 cycles while S toggles arbitrarily → no pulses, locked stays 1, expected unchanged. Resume with the correct successor → no erro.
- Saturation: with ERR_W=2, force 5 locked mismatches (relock between each) → err_count reads 1,2,3,3,3.
- Reset mid-operation: assert reset for 1 cycle while locked with err_count=2 → after that edge locked=0, err_count=0, expected=0. Sample S=2 → SYNC; following 3,4,0 → locked=1.
